// File: rtl/ecdsa_dma_pkg.sv
// Shared constants, state encoding and address helper for the ECDSA DMA responder.
package ecdsa_dma_pkg;
   localparam int DMA_DATA_W = 381;
   localparam int DMA_WORDS  = 12;
   localparam int DMA_BEAT_W = $clog2(DMA_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_DONE,
      ST_ERR
   } dma_state_e;

   function automatic logic addr_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction
endpackage

// File: rtl/dma_beat_buffer.sv
// Word-organised beat buffer: per-beat write, full parallel load, per-beat read.
module dma_beat_buffer #(
   parameter int WORDS  = 12,
   parameter int BEAT_W = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wr_en,
   input  logic [BEAT_W-1:0]     wr_idx,
   input  logic [31:0]           wr_data,
   input  logic                  load_en,
   input  logic [32*WORDS-1:0]   load_data,
   input  logic [BEAT_W-1:0]     rd_idx,
   output logic [31:0]           rd_data,
   output logic [32*WORDS-1:0]   buf_flat
);
   logic [WORDS-1:0][31:0] words_q, words_d;

   // a parallel load (new write value) takes priority over a single-beat update
   always_comb begin
      words_d = words_q;
      if (load_en) begin
         words_d = load_data;
      end else if (wr_en) begin
         words_d[wr_idx] = wr_data;
      end
   end

   // buffer storage
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         words_q <= '0;
      end else begin
         words_q <= words_d;
      end
   end

   assign rd_data  = words_q[rd_idx];
   assign buf_flat = words_q;
endmodule

// File: rtl/ecdsa_dma_responder.sv
// Memory-side responder: moves one DATA_W value per request as a burst of 32-bit beats.
//
// state      | meaning
// ST_IDLE    | waiting for a start pulse
// ST_RD_REQ  | read beat requested, waiting for grant
// ST_RD_WAIT | read beat granted, waiting for rvalid
// ST_WR_REQ  | write beat requested, waiting for grant
// ST_DONE    | one-cycle completion pulse; may launch the pending write
// ST_ERR     | error seen, request dropped; pending write discarded
module ecdsa_dma_responder
   import ecdsa_dma_pkg::*;
#(
   parameter int DATA_W = DMA_DATA_W,
   parameter int WORDS  = DMA_WORDS
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              dma_rx_start,
   input  logic [31:0]       dma_rx_address,
   output logic [DATA_W-1:0] dma_rx_data,
   input  logic              dma_tx_start,
   input  logic [31:0]       dma_tx_address,
   input  logic [DATA_W-1:0] dma_tx_data,
   output logic              dma_done,
   output logic              dma_idle,
   output logic              dma_error,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_err
);
   localparam int BEAT_W = $clog2(WORDS);
   localparam int BUF_W  = 32 * WORDS;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

   dma_state_e        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [31:0]       addr_q, addr_d;
   logic              pend_q, pend_d;
   logic [31:0]       pend_addr_q, pend_addr_d;
   logic [DATA_W-1:0] pend_data_q, pend_data_d;
   logic              error_q, error_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;

   logic              buf_wr_en, buf_load_en;
   logic [BUF_W-1:0]  buf_load_data, buf_flat, rd_final;
   logic [31:0]       buf_rd_data;

   dma_beat_buffer #(.WORDS(WORDS), .BEAT_W(BEAT_W)) u_buf (
      .clk       (clk),
      .resetn    (resetn),
      .wr_en     (buf_wr_en),
      .wr_idx    (beat_q),
      .wr_data   (mem_rdata),
      .load_en   (buf_load_en),
      .load_data (buf_load_data),
      .rd_idx    (beat_q),
      .rd_data   (buf_rd_data),
      .buf_flat  (buf_flat)
   );

   // the last beat lands in the buffer on the same edge, so the result is built around it
   assign rd_final = {mem_rdata, buf_flat[BUF_W-33:0]};

   // next-state, datapath updates and memory-port outputs
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      addr_d        = addr_q;
      pend_d        = pend_q;
      pend_addr_d   = pend_addr_q;
      pend_data_d   = pend_data_q;
      error_d       = error_q;
      rx_data_d     = rx_data_q;
      buf_wr_en     = 1'b0;
      buf_load_en   = 1'b0;
      buf_load_data = BUF_W'(dma_tx_data);
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      dma_done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (dma_rx_start) begin
               addr_d  = dma_rx_address;
               beat_d  = '0;
               error_d = addr_misaligned(dma_rx_address);
               state_d = error_d ? ST_ERR : ST_RD_REQ;
               if (dma_tx_start) begin
                  pend_d      = 1'b1;
                  pend_addr_d = dma_tx_address;
                  pend_data_d = dma_tx_data;
               end
            end else if (dma_tx_start) begin
               addr_d      = dma_tx_address;
               beat_d      = '0;
               buf_load_en = 1'b1;
               error_d     = addr_misaligned(dma_tx_address);
               state_d     = error_d ? ST_ERR : ST_WR_REQ;
            end
         end
         ST_RD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = addr_q + (32'(beat_q) << 2);
            if (mem_gnt) begin
               if (mem_err) begin
                  error_d = 1'b1;
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            if (mem_rvalid) begin
               if (mem_err) begin
                  error_d = 1'b1;
                  state_d = ST_ERR;
               end else begin
                  buf_wr_en = 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     rx_data_d = rd_final[DATA_W-1:0];
                     state_d   = ST_DONE;
                  end else begin
                     beat_d  = beat_q + 1'b1;
                     state_d = ST_RD_REQ;
                  end
               end
            end
         end
         ST_WR_REQ: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q + (32'(beat_q) << 2);
            mem_wdata = buf_rd_data;
            if (mem_gnt) begin
               if (mem_err) begin
                  error_d = 1'b1;
                  state_d = ST_ERR;
               end else if (beat_q == LAST_BEAT) begin
                  state_d = ST_DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            dma_done = 1'b1;
            if (pend_q) begin
               pend_d        = 1'b0;
               addr_d        = pend_addr_q;
               beat_d        = '0;
               buf_load_en   = 1'b1;
               buf_load_data = BUF_W'(pend_data_q);
               error_d       = addr_misaligned(pend_addr_q);
               state_d       = error_d ? ST_ERR : ST_WR_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            pend_d  = 1'b0;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         addr_q      <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         error_q     <= 1'b0;
         rx_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         addr_q      <= addr_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         error_q     <= error_d;
         rx_data_q   <= rx_data_d;
      end
   end

   assign dma_idle    = (state_q == ST_IDLE);
   assign dma_error   = error_q;
   assign dma_rx_data = rx_data_q;
endmodule
